// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Parametrised up/down modulo counter with synchronous clear and load,
// wrap-or-saturate behaviour at the limits, a one-cycle terminal-count pulse
// and a sticky overflow flag. All outputs come straight from registers.
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   When defined, an internal prescaler counts enabled cycles and only every
//   PRESCALE-th enabled cycle becomes a count step. When undefined there is no
//   prescaler and every enabled cycle is a step (PRESCALE is then ignored).
//
// Parameters
//   WIDTH      counter width in bits (2..32)
//   MAX_VALUE  inclusive upper limit (1..2**WIDTH-1)
//   SATURATE   0 = wrap at the limits, 1 = hold at the limits
//   PRESCALE   enabled cycles per count step (>=1, prescaler build only)
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   enable      in   count enable
//   up_down     in   1 = count up, 0 = count down
//   clear       in   synchronous clear of the count to 0
//   load        in   synchronous load of load_value (clamped to MAX_VALUE)
//   load_value  in   value to load
//   ovf_clear   in   clears the sticky overflow flag
//   out         out  counter value
//   tc          out  terminal-count pulse, high the cycle out shows the
//                    post-boundary value
//   overflow    out  sticky boundary flag
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter int unsigned      PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ovf_clear,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Elaboration-time guard against configurations outside the legal ranges.
  if ((WIDTH < 2) || (WIDTH > 32) || (MAX_VALUE == ZERO) || (PRESCALE < 1)) begin : g_bad_params
    $error("mod_updown_counter: illegal parameter set");
  end

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_out_nxt;
  logic             w_tc_nxt;
  logic             w_ovf_nxt;
  logic             w_boundary;
  logic             w_step;
  logic [WIDTH-1:0] w_load_clamped;

  // Loads beyond the modulus are clamped so the count never leaves 0..MAX_VALUE.
  assign w_load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ZERO = {PS_W{1'b0}};
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] r_ps;
  logic [PS_W-1:0] w_ps_nxt;

  // Prescaler phase: clear/load restart it, enable low freezes it.
  always_comb begin
    w_ps_nxt = r_ps;
    w_step   = 1'b0;
    if (clear || load) begin
      w_ps_nxt = PS_ZERO;
    end else if (enable) begin
      if (r_ps == PS_LAST) begin
        w_ps_nxt = PS_ZERO;
        w_step   = 1'b1;
      end else begin
        w_ps_nxt = r_ps + PS_ONE;
      end
    end else begin
      w_ps_nxt = r_ps;
    end
  end

  // Prescaler phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ps <= PS_ZERO;
    end else begin
      r_ps <= w_ps_nxt;
    end
  end
`else
  assign w_step = enable;
`endif

  // Next count, terminal-count and overflow: clear > load > counting step.
  always_comb begin
    w_out_nxt  = r_out;
    w_boundary = 1'b0;
    if (clear) begin
      w_out_nxt = ZERO;
    end else if (load) begin
      w_out_nxt = w_load_clamped;
    end else if (w_step) begin
      if (up_down) begin
        if (r_out >= MAX_VALUE) begin
          w_boundary = 1'b1;
          w_out_nxt  = SATURATE ? MAX_VALUE : ZERO;
        end else begin
          w_out_nxt = r_out + ONE;
        end
      end else begin
        if (r_out == ZERO) begin
          w_boundary = 1'b1;
          w_out_nxt  = SATURATE ? ZERO : MAX_VALUE;
        end else begin
          w_out_nxt = r_out - ONE;
        end
      end
    end else begin
      w_out_nxt = r_out;
    end

    w_tc_nxt = w_boundary;

    // A boundary event on the same edge as ovf_clear keeps the flag set.
    if (w_boundary) begin
      w_ovf_nxt = 1'b1;
    end else if (ovf_clear) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  // Output state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= ZERO;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      r_tc  <= w_tc_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign out      = r_out;
  assign tc       = r_tc;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//
// Drives a wrapping and a saturating instance (WIDTH=4, MAX_VALUE=9) with the
// same inputs and compares both against an arithmetic reference model. A
// directed sequence follows the behaviours of interest, then a randomized run.
// With COUNTER_PRESCALE_EN defined, both instances use PRESCALE=3 and the
// model counts enabled cycles accordingly.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;

  localparam int W   = 4;
  localparam int MAX = 9;
`ifdef COUNTER_PRESCALE_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif

  logic         clk;
  logic         reset;
  logic         enable;
  logic         up_down;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic         ovf_clear;

  logic [W-1:0] out_w, out_s;
  logic         tc_w, tc_s;
  logic         ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = wrap, 1 = saturate
  int m_out [2];
  int m_tc  [2];
  int m_ovf [2];
  int m_ps;

  mod_updown_counter #(
    .WIDTH(W), .MAX_VALUE(4'd9), .SATURATE(1'b0), .PRESCALE(PS)
  ) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .ovf_clear(ovf_clear),
    .out(out_w), .tc(tc_w), .overflow(ovf_w)
  );

  mod_updown_counter #(
    .WIDTH(W), .MAX_VALUE(4'd9), .SATURATE(1'b1), .PRESCALE(PS)
  ) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .ovf_clear(ovf_clear),
    .out(out_s), .tc(tc_s), .overflow(ovf_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0;
      m_tc[i]  = 0;
      m_ovf[i] = 0;
    end
    m_ps = 0;
  endtask

  // One clock edge of the specified behaviour, with plain integer arithmetic.
  task automatic model_edge();
    bit step;
    bit bnd;
    int lv;
    step = 1'b0;
    if (!clear && !load && enable) begin
      step = (m_ps == PS - 1);
      m_ps = (m_ps + 1) % PS;
    end else if (clear || load) begin
      m_ps = 0;
    end
    lv = int'(load_value);
    for (int i = 0; i < 2; i++) begin
      bnd = 1'b0;
      if (clear) begin
        m_out[i] = 0;
      end else if (load) begin
        m_out[i] = (lv > MAX) ? MAX : lv;
      end else if (step) begin
        if (up_down) begin
          bnd = (m_out[i] + 1 > MAX);
          if (i == 0) m_out[i] = (m_out[i] + 1) % (MAX + 1);
          else        m_out[i] = bnd ? MAX : m_out[i] + 1;
        end else begin
          bnd = (m_out[i] - 1 < 0);
          if (i == 0) m_out[i] = (m_out[i] + MAX) % (MAX + 1);
          else        m_out[i] = bnd ? 0 : m_out[i] - 1;
        end
      end
      m_tc[i] = bnd;
      if (bnd) m_ovf[i] = 1;
      else if (ovf_clear) m_ovf[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/wrap.out"}, 32'(out_w), 32'(m_out[0]));
    chk({tag, "/wrap.tc"},  32'(tc_w),  32'(m_tc[0]));
    chk({tag, "/wrap.ovf"}, 32'(ovf_w), 32'(m_ovf[0]));
    chk({tag, "/sat.out"},  32'(out_s), 32'(m_out[1]));
    chk({tag, "/sat.tc"},   32'(tc_s),  32'(m_tc[1]));
    chk({tag, "/sat.ovf"},  32'(ovf_s), 32'(m_ovf[1]));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit en, input bit ud, input bit clr, input bit ld,
                        input int lv, input bit oc);
    enable     = en;
    up_down    = ud;
    clear      = clr;
    load       = ld;
    load_value = W'(lv);
    ovf_clear  = oc;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();

    // reset state while reset is held across an edge
    #12;
    check_all("reset");
    chk("reset/const.out", 32'(out_w), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // count up 12 cycles: wrap passes 9 -> 0 with a tc pulse
    set_in(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc($sformatf("up%0d", i));

    // clear, then down from 0 -> wrap to 9
    set_in(0, 0, 1, 0, 0, 0);
    cyc("clr");
    set_in(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < PS; i++) cyc($sformatf("down%0d", i));
    set_in(0, 0, 0, 0, 0, 1);
    cyc("ovfclr");
    set_in(0, 0, 0, 0, 0, 0);
    cyc("idle");

    // load of 15 clamps to 9, then up steps at the limit
    set_in(0, 1, 0, 1, 15, 0);
    cyc("load15");
    set_in(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * PS; i++) cyc($sformatf("sat%0d", i));

    // priority: clear over load over count
    set_in(1, 1, 1, 1, 5, 0);
    cyc("clr_ld_en");
    set_in(1, 1, 0, 1, 5, 0);
    cyc("ld_en");
    set_in(0, 1, 0, 0, 0, 1);
    cyc("ovfclr2");
    set_in(0, 1, 0, 1, 9, 0);
    cyc("load9");
    set_in(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < PS; i++) cyc($sformatf("bnd_oc%0d", i));

    // asynchronous reset in the middle of a cycle at out = 7
    set_in(1, 1, 0, 1, 7, 0);
    cyc("load7");
    set_in(1, 1, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    reset = 1'b0;
    for (int i = 0; i < PS; i++) cyc($sformatf("resume%0d", i));

    // enable gap then more counting (prescaler phase must hold)
    set_in(1, 1, 0, 0, 0, 0);
    cyc("gap_a");
    set_in(0, 1, 0, 0, 0, 0);
    cyc("gap_b");
    cyc("gap_c");
    set_in(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc($sformatf("gap_run%0d", i));

    // randomized run
    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up_down = ~up_down;
      clear      = ($urandom_range(0, 24) == 0);
      load       = ($urandom_range(0, 14) == 0);
      load_value = W'($urandom_range(0, 15));
      ovf_clear  = ($urandom_range(0, 9) == 0);
      cyc($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
